quadrature_decoder: RTL and testbench

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

---
 rtl/quadrature_decoder.sv | 147 ++++++++++++++
 tb/tb_quadrature_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizes and glitch-filters channels A/B, then
// turns legal Gray-code transitions into step strobes, direction and a wrapping position.
module quadrature_decoder #(
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned ERR_WIDTH     = 16
) (
    input  logic                  clock,
    input  logic                  system_reset,
    input  logic                  enc_a,
    input  logic                  enc_b,
    input  logic                  position_clear,
    output logic                  step_pulse,
    output logic                  direction,
    output logic signed [31:0]    position,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic                  error_flag
);

    localparam logic [15:0] FILT_LAST = 16'(FILTER_CYCLES - 1);

    logic [1:0]  meta_r;
    logic [1:0]  sync_r;
    logic [1:0]  filt_r;
    logic [1:0]  prev_r;
    logic [15:0] cnt_a_r;
    logic [15:0] cnt_b_r;
    logic        prime_r;
    logic        armed_r;
    logic [1:0]  change_s;
    logic        legal_s;
    logic        illegal_s;
    logic        fwd_s;
    logic        settled_s;

    // Next {filtered level, counter} for one channel.
    function automatic logic [16:0] filter_step(input logic sync, input logic filt,
                                                input logic [15:0] cnt);
        if (sync == filt) begin
            filter_step = {filt, 16'd0};
        end else if (cnt == FILT_LAST) begin
            filter_step = {sync, 16'd0};
        end else begin
            filter_step = {filt, cnt + 16'd1};
        end
    endfunction

    // Pair ordering is {a,b}; forward runs 00->10->11->01->00.
    function automatic logic step_is_forward(input logic [1:0] prev, input logic [1:0] cur);
        case ({prev, cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_is_forward = 1'b1;
            default:                                 step_is_forward = 1'b0;
        endcase
    endfunction

    // Two-flop synchronizers for both channels.
    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
        end else begin
            meta_r <= {enc_a, enc_b};
            sync_r <= meta_r;
        end
    end

    // Independent glitch filters for A and B.
    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            filt_r  <= 2'b00;
            cnt_a_r <= 16'd0;
            cnt_b_r <= 16'd0;
        end else begin
            {filt_r[1], cnt_a_r} <= filter_step(sync_r[1], filt_r[1], cnt_a_r);
            {filt_r[0], cnt_b_r} <= filter_step(sync_r[0], filt_r[0], cnt_b_r);
        end
    end

    // Transition classification; nothing is decoded until the post-reset level has settled,
    // so a pair already non-zero at reset release only initializes the previous pair.
    always_comb begin
        change_s  = filt_r ^ prev_r;
        legal_s   = 1'b0;
        illegal_s = 1'b0;
        fwd_s     = 1'b0;
        settled_s = prime_r && (meta_r == sync_r) && (sync_r == filt_r);
        if (armed_r) begin
            case (change_s)
                2'b01, 2'b10: begin
                    legal_s = 1'b1;
                    fwd_s   = step_is_forward(prev_r, filt_r);
                end
                2'b11:   illegal_s = 1'b1;
                default: legal_s   = 1'b0;
            endcase
        end else begin
            legal_s   = 1'b0;
            illegal_s = 1'b0;
        end
    end

    // Previous filtered pair and post-reset arming.
    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            prev_r  <= 2'b00;
            prime_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            prev_r  <= filt_r;
            prime_r <= 1'b1;
            if (settled_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Registered outputs; position_clear overrides position and error state only.
    always_ff @(posedge clock or posedge system_reset) begin
        if (system_reset) begin
            step_pulse  <= 1'b0;
            direction   <= 1'b1;
            position    <= 32'sd0;
            error_count <= {ERR_WIDTH{1'b0}};
            error_flag  <= 1'b0;
        end else begin
            step_pulse <= legal_s;
            if (legal_s) begin
                direction <= fwd_s;
            end
            if (position_clear) begin
                position    <= 32'sd0;
                error_count <= {ERR_WIDTH{1'b0}};
                error_flag  <= 1'b0;
            end else begin
                if (legal_s) begin
                    position <= fwd_s ? position + 32'sd1 : position - 32'sd1;
                end
                if (illegal_s) begin
                    if (error_count != {ERR_WIDTH{1'b1}}) begin
                        error_count <= error_count + ERR_WIDTH'(1);
                    end
                    error_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: an event-level model predicts each step/error from the
// pair change the bench drives, checked every cycle, plus literal checkpoints.
module tb_quadrature_decoder;

    localparam int LAT = 2 + 4 + 1;
    localparam int FWD = 0;
    localparam int REV = 1;
    localparam int ILL = 2;

    typedef struct {
        int kind;
        int due;
    } ev_t;

    logic               clock = 1'b0;
    logic               system_reset = 1'b1;
    logic               enc_a = 1'b0;
    logic               enc_b = 1'b0;
    logic               position_clear = 1'b0;
    logic               step_pulse;
    logic               direction;
    logic signed [31:0] position;
    logic [15:0]        error_count;
    logic               error_flag;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        clr_q = 1'b0;
    ev_t         q[$];
    logic [31:0] mpos = 32'd0;
    logic        mdir = 1'b1;
    logic [15:0] merr = 16'd0;
    logic        mflag = 1'b0;

    quadrature_decoder #(.FILTER_CYCLES(4), .ERR_WIDTH(16)) dut (
        .clock(clock),
        .system_reset(system_reset),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .position_clear(position_clear),
        .step_pulse(step_pulse),
        .direction(direction),
        .position(position),
        .error_count(error_count),
        .error_flag(error_flag)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        clr_q <= position_clear;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Model: a driven pair change takes effect exactly LAT clocks later.
    always @(negedge clock) begin
        logic exp_pulse;
        ev_t  ev;
        exp_pulse = 1'b0;
        if (system_reset) begin
            mpos  = 32'd0;
            mdir  = 1'b1;
            merr  = 16'd0;
            mflag = 1'b0;
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                ev = q.pop_front();
                case (ev.kind)
                    FWD: begin exp_pulse = 1'b1; mdir = 1'b1; mpos = mpos + 32'd1; end
                    REV: begin exp_pulse = 1'b1; mdir = 1'b0; mpos = mpos - 32'd1; end
                    default: begin
                        if (merr != 16'hFFFF) merr = merr + 16'd1;
                        mflag = 1'b1;
                    end
                endcase
            end
            if (clr_q) begin
                mpos  = 32'd0;
                merr  = 16'd0;
                mflag = 1'b0;
            end
        end
        chk("step_pulse", {31'd0, step_pulse}, {31'd0, exp_pulse});
        chk("direction", {31'd0, direction}, {31'd0, mdir});
        chk("position", position, mpos);
        chk("error_count", {16'd0, error_count}, {16'd0, merr});
        chk("error_flag", {31'd0, error_flag}, {31'd0, mflag});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic push(input int kind);
        ev_t e;
        e.kind = kind;
        e.due  = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] p, input int kind);
        {enc_a, enc_b} = p;
        push(kind);
        tick(20);
    endtask

    initial begin
        logic [1:0] fseq[4];
        logic [1:0] rseq[3];
        fseq = '{2'b10, 2'b11, 2'b01, 2'b00};
        rseq = '{2'b01, 2'b11, 2'b10};

        tick(3);
        chk("reset_position", position, 32'd0);
        chk("reset_direction", {31'd0, direction}, 32'd1);
        chk("reset_step", {31'd0, step_pulse}, 32'd0);
        system_reset = 1'b0;
        tick(10);

        for (int i = 0; i < 8; i++) drive(fseq[i % 4], FWD);
        chk("fwd8_position", position, 32'd8);
        chk("fwd8_direction", {31'd0, direction}, 32'd1);
        chk("fwd8_errors", {16'd0, error_count}, 32'd0);

        for (int i = 0; i < 3; i++) drive(rseq[i], REV);
        chk("rev3_position", position, 32'd5);
        chk("rev3_direction", {31'd0, direction}, 32'd0);

        for (int i = 0; i < 2; i++) begin
            enc_a = 1'b0; tick(3); enc_a = 1'b1; tick(15);
            enc_b = 1'b1; tick(3); enc_b = 1'b0; tick(15);
        end
        chk("glitch_position", position, 32'd5);

        drive(2'b00, REV);
        drive(2'b11, ILL);
        chk("illegal_count", {16'd0, error_count}, 32'd1);
        chk("illegal_flag", {31'd0, error_flag}, 32'd1);
        chk("illegal_position", position, 32'd4);

        position_clear = 1'b1; tick(1); position_clear = 1'b0; tick(5);
        chk("clear_position", position, 32'd0);
        chk("clear_errors", {16'd0, error_count}, 32'd0);
        chk("clear_flag", {31'd0, error_flag}, 32'd0);

        drive(2'b10, REV);
        chk("wrap_down", position, 32'hFFFF_FFFF);
        drive(2'b11, FWD);
        chk("wrap_up", position, 32'h0000_0000);
        drive(2'b01, FWD);
        chk("pre_clear_step", position, 32'd1);

        {enc_a, enc_b} = 2'b11;
        push(REV);
        tick(LAT - 1);
        position_clear = 1'b1; tick(1); position_clear = 1'b0; tick(13);
        chk("clear_step_position", position, 32'd0);
        chk("clear_step_direction", {31'd0, direction}, 32'd0);

        enc_a = 1'b0; tick(3);
        system_reset = 1'b1; enc_a = 1'b1; tick(3);
        chk("midreset_step", {31'd0, step_pulse}, 32'd0);
        chk("midreset_direction", {31'd0, direction}, 32'd1);
        system_reset = 1'b0; tick(30);
        chk("post_reset_position", position, 32'd0);
        chk("post_reset_errors", {16'd0, error_count}, 32'd0);
        chk("post_reset_flag", {31'd0, error_flag}, 32'd0);
        chk("post_reset_direction", {31'd0, direction}, 32'd1);

        drive(2'b01, FWD);
        chk("post_reset_step", position, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
